io_port_requester: RTL and testbench

Device-side bus port for one I/O peripheral on the DMA interconnect. It raises a transfer request `intReq` toward the arbitration block and waits for `intAck`. After the grant it moves a block of 32-bit words over the shared tri-state `Data` bus, pacing each word with `hReady`. It drives an incrementing word address on `inAddress` and buffers data in local FIFOs between the peripheral core and the bus.

---
 rtl/io_bus_pkg.sv | 36 +++
 rtl/io_word_fifo.sv | 54 +++++
 rtl/io_port_requester.sv | 143 ++++++++++++++
 tb/tb_io_port_requester.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared constants and types for the DMA interconnect I/O port.
package io_bus_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    // Bit positions inside the 3-bit intReq vector
    localparam int INTREQ_BLK   = 0;
    localparam int INTREQ_VALID = 1;
    localparam int INTREQ_DIR   = 2;

    // Transfer sequencer states
    typedef logic [2:0] ioState_t;
    localparam ioState_t ST_IDLE    = 3'd0;
    localparam ioState_t ST_REQ     = 3'd1;
    localparam ioState_t ST_XFER    = 3'd2;
    localparam ioState_t ST_RELEASE = 3'd3;
    localparam ioState_t ST_ERR     = 3'd4;

    // Attributes of the transfer latched when it is launched
    typedef struct packed {
        logic dir;  // 1 = device to bus
        logic blk;  // more than one word
    } xferDesc_t;

    // Assemble the request vector; all-zero whenever no request is active
    function automatic logic [2:0] packIntReq(input logic active, input xferDesc_t d);
        logic [2:0] r;
        r = '0;
        r[INTREQ_VALID] = active;
        r[INTREQ_DIR]   = active & d.dir;
        r[INTREQ_BLK]   = active & d.blk;
        return r;
    endfunction

endpackage

// File: rtl/io_word_fifo.sv
// Synchronous word FIFO with registered occupancy. Push into a full FIFO and
// pop from an empty one are ignored; push and pop together keep the count.
module io_word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = mem[rdPtr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    // Word storage
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the cleared pointers make old words unreachable.
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/io_port_requester.sv
// Device-side DMA bus port: requests the bus, then moves a block of words
// between the local TX/RX FIFOs and the shared tri-state Data bus.
module io_port_requester
    import io_bus_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [2:0]        intReq,
    input  logic              intAck,
    output logic              hReady,
    output logic [ADDR_W-1:0] inAddress,
    inout  wire  [DATA_W-1:0] Data
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    ioState_t          state;
    ioState_t          stateNext;
    xferDesc_t         desc;
    logic [ADDR_W-1:0] remaining;
    logic [TW-1:0]     ackTimer;
    logic              timerExpired;
    logic              launch;
    logic              inXfer;
    logic              beat;

    logic              txFull, txEmpty, rxFull, rxEmpty;
    logic [DATA_W-1:0] txHead;
    logic [CW-1:0]     txCount, rxCount;
    logic              unusedCounts;

    // Occupancy counts are not needed at this level
    assign unusedCounts = ^{txCount, rxCount};

    io_word_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) txFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_valid && wr_ready),
        .pushData (wr_data),
        .pop      (beat && desc.dir),
        .head     (txHead),
        .full     (txFull),
        .empty    (txEmpty),
        .count    (txCount)
    );

    io_word_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) rxFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (beat && !desc.dir),
        .pushData (Data),
        .pop      (rd_valid && rd_ready),
        .head     (rd_data),
        .full     (rxFull),
        .empty    (rxEmpty),
        .count    (rxCount)
    );

    assign launch       = (state == ST_IDLE) && start && (len != '0);
    assign inXfer       = (state == ST_XFER);
    assign timerExpired = (ackTimer == TW'(ACK_TIMEOUT - 1));

    // A word can move when the FIFO on the device side has room/data
    assign hReady = inXfer && (desc.dir ? !txEmpty : !rxFull);
    assign beat   = hReady && intAck;

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_RELEASE);
    assign timeout_err = (state == ST_ERR);
    assign intReq      = packIntReq((state == ST_REQ) || inXfer, desc);
    assign wr_ready    = !txFull;
    assign rd_valid    = !rxEmpty;

    // Drive the bus only while a valid TX word is presented
    assign Data = (inXfer && desc.dir && !txEmpty) ? txHead : 'z;

    // Next-state selection for the transfer sequencer
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (launch) stateNext = ST_REQ;
            end
            ST_REQ: begin
                if (intAck)            stateNext = ST_XFER;
                else if (timerExpired) stateNext = ST_ERR;
            end
            ST_XFER: begin
                if (beat && remaining == ADDR_W'(1)) stateNext = ST_RELEASE;
                else if (!intAck && timerExpired)    stateNext = ST_ERR;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // State, transfer descriptor, address/count and grant-timeout registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            desc      <= '0;
            remaining <= '0;
            inAddress <= '0;
            ackTimer  <= '0;
        end else begin
            state <= stateNext;

            if (launch) begin
                desc.dir  <= dir;
                desc.blk  <= (len > ADDR_W'(1));
                remaining <= len;
                inAddress <= base_addr;
            end else if (beat) begin
                inAddress <= inAddress + 1'b1;
                remaining <= remaining - 1'b1;
            end

            // Counts consecutive cycles without a grant; any grant clears it
            if ((state == ST_REQ || inXfer) && !intAck && !timerExpired)
                ackTimer <= ackTimer + 1'b1;
            else
                ackTimer <= '0;
        end
    end

endmodule

// File: tb/tb_io_port_requester.sv
// Self-checking bench for io_port_requester: table-driven transfers plus
// hand-written sequences for stalls, timeouts and reset.
module tb_io_port_requester;
    import io_bus_pkg::*;

    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst, start, dir;
    logic [5:0]  base_addr, len;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready, rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready, busy, done, timeout_err;
    logic [2:0]  intReq;
    logic        intAck, hReady;
    logic [5:0]  inAddress;
    wire  [31:0] Data;

    // Bus-side model: probe drive for high-Z checks, word source for reads
    logic        probeOn;
    logic [31:0] probeVal;
    logic        readMode;
    logic [31:0] readWords [256];
    logic [7:0]  rdIdx;

    assign Data = probeOn ? probeVal : (readMode ? readWords[rdIdx] : 32'bz);

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } beat_t;

    beat_t       expQ [$];
    logic [31:0] rxQ [$];
    beat_t       monE;

    typedef struct {
        logic        dir;
        logic [5:0]  base;
        logic [5:0]  len;
        int          ackDelay;
        logic [31:0] seed;
        logic [31:0] step;
        logic [2:0]  expIntReq;
        int          expDoneAt;
    } vec_t;

    vec_t vecs [6];

    int nChecks = 0;
    int nFails  = 0;

    io_port_requester #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dir         (dir),
        .base_addr   (base_addr),
        .len         (len),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .intReq      (intReq),
        .intAck      (intAck),
        .hReady      (hReady),
        .inAddress   (inAddress),
        .Data        (Data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive two complementary patterns; they only read back intact if the DUT is off the bus
    task automatic checkBusZ(input string name);
        probeVal = 32'h5A5A_C3C3;
        probeOn  = 1'b1;
        #1;
        check({name, "_busz0"}, Data, 32'h5A5A_C3C3);
        probeVal = 32'hA5A5_3C3C;
        #1;
        check({name, "_busz1"}, Data, 32'hA5A5_3C3C);
        probeOn = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_intReq"},      32'(intReq),      32'd0);
        check({tag, "_hReady"},      32'(hReady),      32'd0);
        check({tag, "_inAddress"},   32'(inAddress),   32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_wr_ready"},    32'(wr_ready),    32'd1);
        check({tag, "_rd_valid"},    32'(rd_valid),    32'd0);
        checkBusZ(tag);
    endtask

    // Read-word source advances on every accepted read beat
    always @(posedge clk) begin
        if (rst) rdIdx <= '0;
        else if (readMode && intAck && hReady) rdIdx <= rdIdx + 8'd1;
    end

    // Beat monitor: every completed word is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && intAck && hReady) begin
            check("beat_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                monE = expQ.pop_front();
                check("beat_addr", 32'(inAddress), 32'(monE.addr));
                check("beat_data", Data, monE.data);
            end
        end
    end

    task automatic loadWords(input logic d, input logic [5:0] base, input int n,
                             input logic [31:0] seed, input logic [31:0] step, input string tag);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = seed + step * 32'(i);
            expQ.push_back('{addr: base + 6'(i), data: w});
            if (d) begin
                check({tag, "_wr_ready_fill"}, 32'(wr_ready), 32'd1);
                wr_valid = 1'b1;
                wr_data  = w;
                tick();
            end else begin
                readWords[rdIdx + 8'(i)] = w;
                rxQ.push_back(w);
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic launch(input logic d, input logic [5:0] base, input logic [5:0] n);
        readMode  = !d;
        start     = 1'b1;
        dir       = d;
        base_addr = base;
        len       = n;
        tick();
        start = 1'b0;
    endtask

    task automatic drainRx(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
            if (rxQ.size() != 0) check({tag, "_rd_data"}, rd_data, rxQ.pop_front());
            rd_ready = 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        check({tag, "_rd_empty"}, 32'(rd_valid), 32'd0);
    endtask

    task automatic runVector(input vec_t v, input int vi);
        int    cyc;
        int    doneAt;
        string tag;
        tag = $sformatf("vec%0d", vi);
        loadWords(v.dir, v.base, int'(v.len), v.seed, v.step, tag);
        if (v.dir && int'(v.len) == DEPTH)
            check({tag, "_tx_full"}, 32'(wr_ready), 32'd0);
        launch(v.dir, v.base, v.len);
        check({tag, "_busy_t1"}, 32'(busy), 32'd1);
        check({tag, "_addr_load"}, 32'(inAddress), 32'(v.base));
        cyc    = 1;
        doneAt = -1;
        while (cyc < 40) begin
            intAck = (cyc >= v.ackDelay);
            if (done) begin
                doneAt = cyc;
                break;
            end
            check({tag, "_intReq"}, 32'(intReq), 32'(v.expIntReq));
            tick();
            cyc++;
        end
        check({tag, "_done_cycle"}, 32'(doneAt), 32'(v.expDoneAt));
        check({tag, "_intReq_at_done"}, 32'(intReq), 32'd0);
        intAck   = 1'b0;
        readMode = 1'b0;
        tick();
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_once"}, 32'(done), 32'd0);
        if (!v.dir) drainRx(int'(v.len), tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int doneAt;

        //          dir   base    len    k   seed          step          intReq  done
        vecs[0] = '{1'b1, 6'h10, 6'd4, 3, 32'h0000_00A0, 32'h0000_0001, 3'b111, 8};
        vecs[1] = '{1'b0, 6'h3E, 6'd3, 2, 32'h0000_0011, 32'h0000_0011, 3'b011, 6};
        vecs[2] = '{1'b1, 6'h3F, 6'd1, 1, 32'hDEAD_BEEF, 32'h0000_0000, 3'b110, 3};
        vecs[3] = '{1'b0, 6'h00, 6'd1, 1, 32'h1234_5678, 32'h0000_0000, 3'b010, 3};
        vecs[4] = '{1'b1, 6'h05, 6'd8, 2, 32'h1000_0000, 32'h0101_0101, 3'b111, 11};
        vecs[5] = '{1'b0, 6'h3C, 6'd8, 1, 32'hF000_000F, 32'h0000_0100, 3'b011, 10};

        rst = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; intAck = 1'b0;
        probeOn = 1'b0; probeVal = '0; readMode = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkResetValues("reset");

        for (int i = 0; i < 6; i++) runVector(vecs[i], i);

        // start with len=0 is dropped
        start = 1'b1; dir = 1'b1; base_addr = 6'h2A; len = 6'd0;
        tick();
        start = 1'b0;
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_intReq", 32'(intReq), 32'd0);
        tick();
        check("len0_done", 32'(done), 32'd0);

        // Write with an empty TX FIFO at grant: stalls until the core pushes
        launch(1'b1, 6'h20, 6'd2);
        intAck = 1'b1;
        tick();
        check("emptytx_hready0", 32'(hReady), 32'd0);
        checkBusZ("emptytx");
        tick();
        check("emptytx_hready_hold", 32'(hReady), 32'd0);
        expQ.push_back('{addr: 6'h20, data: 32'hC0DE_0000});
        wr_valid = 1'b1; wr_data = 32'hC0DE_0000;
        tick();
        wr_valid = 1'b0;
        check("emptytx_hready1", 32'(hReady), 32'd1);
        check("emptytx_data", Data, 32'hC0DE_0000);
        tick();
        check("emptytx_hready_again", 32'(hReady), 32'd0);
        check("emptytx_addr", 32'(inAddress), 32'h21);
        expQ.push_back('{addr: 6'h21, data: 32'hC0DE_0001});
        wr_valid = 1'b1; wr_data = 32'hC0DE_0001;
        tick();
        wr_valid = 1'b0;
        check("emptytx_hready2", 32'(hReady), 32'd1);
        tick();
        check("emptytx_done", 32'(done), 32'd1);
        intAck = 1'b0;
        tick();
        check("emptytx_idle", 32'(busy), 32'd0);

        // Grant dropped for three cycles mid-transfer
        loadWords(1'b1, 6'h30, 4, 32'h0000_00D0, 32'h1, "ackdrop");
        launch(1'b1, 6'h30, 6'd4);
        cyc = 1;
        doneAt = -1;
        while (cyc < 40) begin
            intAck = !(cyc >= 4 && cyc <= 6);
            if (done) begin
                doneAt = cyc;
                break;
            end
            if (cyc >= 4 && cyc <= 6) begin
                check("ackdrop_addr_held", 32'(inAddress), 32'h32);
                check("ackdrop_pending", 32'(expQ.size()), 32'd2);
            end
            tick();
            cyc++;
        end
        check("ackdrop_done_cycle", 32'(doneAt), 32'd9);
        intAck = 1'b0;
        tick();

        // Grant lost in XFER for ACK_TIMEOUT cycles: abort, keep RX contents
        readWords[rdIdx] = 32'h7777_0001;
        expQ.push_back('{addr: 6'h18, data: 32'h7777_0001});
        rxQ.push_back(32'h7777_0001);
        launch(1'b0, 6'h18, 6'd3);
        cyc = 1;
        doneAt = -1;
        while (cyc < 40) begin
            intAck = (cyc <= 2);
            if (timeout_err) begin
                doneAt = cyc;
                break;
            end
            tick();
            cyc++;
        end
        check("xferto_cycle", 32'(doneAt), 32'd11);
        check("xferto_intReq", 32'(intReq), 32'd0);
        check("xferto_no_done", 32'(done), 32'd0);
        readMode = 1'b0;
        tick();
        check("xferto_idle", 32'(busy), 32'd0);
        check("xferto_pulse", 32'(timeout_err), 32'd0);
        drainRx(1, "xferto");

        // Grant never arrives: abort ACK_TIMEOUT cycles after entering REQ
        launch(1'b1, 6'h00, 6'd1);
        intAck = 1'b0;
        cyc = 1;
        doneAt = -1;
        while (cyc < 40) begin
            if (timeout_err) begin
                doneAt = cyc;
                break;
            end
            check("reqto_intReq", 32'(intReq), 32'b110);
            tick();
            cyc++;
        end
        check("reqto_cycle", 32'(doneAt), 32'd9);
        check("reqto_intReq_low", 32'(intReq), 32'd0);
        check("reqto_busy_err", 32'(busy), 32'd1);
        tick();
        check("reqto_idle", 32'(busy), 32'd0);

        // Reset in the middle of a read transfer
        loadWords(1'b0, 6'h08, 5, 32'h5500_0000, 32'h1, "rstmid");
        launch(1'b0, 6'h08, 6'd5);
        intAck = 1'b1;
        repeat (3) tick();
        check("rstmid_in_xfer", 32'(inAddress), 32'h0A);
        rst = 1'b1; intAck = 1'b0; readMode = 1'b0;
        tick();
        rst = 1'b0;
        expQ.delete();
        rxQ.delete();
        checkResetValues("rstmid");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstmid_no_done", 32'(done), 32'd0);
            check("rstmid_no_err", 32'(timeout_err), 32'd0);
        end

        check("expq_drained", 32'(expQ.size()), 32'd0);
        check("rxq_drained", 32'(rxQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
